// File: rtl/prach_hb2_pack.sv
// -----------------------------------------------------------------------------
// prach_hb2_pack
//
// Polyphase pair packer in front of the PRACH second half-band decimator.
// A TDM stream of complex samples (one per cycle, tagged with a channel index)
// comes in. Per channel, consecutive samples are paired into an even/odd
// polyphase pair. Both halves are emitted together, one cycle after the odd
// sample arrives, with a single valid strobe.
//
// Ports:
//   clk       processing clock
//   rst       synchronous active-high reset
//   din_dq    input sample, [15:0] = I, [31:16] = Q
//   din_dv    input valid
//   din_chn   channel index of din_dq
//   sync_in   frame sync, only meaningful when din_dv = 1
//   dout_dp1  even (older) sample, [0] = I, [1] = Q
//   dout_dp2  odd (newer) sample,  [0] = I, [1] = Q
//   dout_dv   single-cycle pair strobe
//   dout_chn  channel index of the pair
//   sync_out  pair carries the frame-sync sample in dout_dp1
//   err       sticky error flag (lost pending samples or bad channel index)
// -----------------------------------------------------------------------------
module prach_hb2_pack #(
   parameter int NUM_CHN = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      din_dq,
   input  logic             din_dv,
   input  logic [7:0]       din_chn,
   input  logic             sync_in,
   output logic [1:0][15:0] dout_dp1,
   output logic [1:0][15:0] dout_dp2,
   output logic             dout_dv,
   output logic [7:0]       dout_chn,
   output logic             sync_out,
   output logic             err
);

   localparam int AW = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;

   // Held even samples. Only read while the channel's phase bit is set, so
   // the contents need no reset.
   logic [31:0]        mem_q [NUM_CHN];

   logic [NUM_CHN-1:0] phase_q, phase_d;
   logic [NUM_CHN-1:0] sflag_q, sflag_d;

   logic [1:0][15:0]   dp1_q, dp2_q;
   logic [7:0]         chn_q;
   logic               dv_q;
   logic               sync_q;
   logic               err_q;

   logic [AW-1:0]      idx;
   logic               in_range;
   logic               accept;
   logic               held_phase;
   logic               held_sync;
   logic               any_pend;
   logic               store;
   logic               pair;

   assign idx        = din_chn[AW-1:0];
   // Nine-bit compare so that NUM_CHN = 256 still works.
   assign in_range   = ({1'b0, din_chn} < 9'(NUM_CHN));
   assign accept     = din_dv && in_range;
   assign held_phase = phase_q[idx];
   assign held_sync  = sflag_q[idx];
   assign any_pend   = |phase_q;

   // A sync sample always restarts its channel as the even half, even when an
   // even sample was already waiting.
   assign store = accept && (sync_in || !held_phase);
   assign pair  = accept && !sync_in && held_phase;

   // Per-channel phase and held-sync next state. A sync clears every phase
   // bit; the channel addressed by the sync beat is then re-armed by 'store'.
   generate
      for (genvar gi = 0; gi < NUM_CHN; gi++) begin : g_chn
         logic sel;
         assign sel = accept && (idx == AW'(gi));
         assign phase_d[gi] = (sel && store)     ? 1'b1 :
                              (accept && sync_in) ? 1'b0 :
                              (sel && pair)       ? 1'b0 :
                                                    phase_q[gi];
         assign sflag_d[gi] = (sel && store) ? sync_in : sflag_q[gi];
      end
   endgenerate

   // Held-sample memory write port. One input per cycle means a write and a
   // pairing read never target the same slot in the same cycle, and a write
   // is already committed by the time the next beat of that channel reads it.
   always_ff @(posedge clk) begin
      if (store && !rst) begin
         mem_q[idx] <= din_dq;
      end
   end

   // Registered read port plus output stage. The output registers only load
   // on pair cycles so the data buses hold their last pair in between.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= '0;
         sflag_q <= '0;
         dp1_q   <= '0;
         dp2_q   <= '0;
         chn_q   <= '0;
         dv_q    <= 1'b0;
         sync_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         sflag_q <= sflag_d;
         dv_q    <= pair;
         sync_q  <= pair && held_sync;
         if (pair) begin
            dp1_q <= mem_q[idx];
            dp2_q <= din_dq;
            chn_q <= din_chn;
         end
         if ((din_dv && !in_range) || (accept && sync_in && any_pend)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign dout_dp1 = dp1_q;
   assign dout_dp2 = dp2_q;
   assign dout_chn = chn_q;
   assign dout_dv  = dv_q;
   assign sync_out = sync_q;
   assign err      = err_q;

endmodule
